// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle for the iterative multiply/divide unit.
//
// Handshake: a request transfers on a rising clock edge where valid_i && ready_o
// are both high; a result transfers on a rising edge where valid_o && ready_i are
// both high. Once raised, valid_o and result_o stay stable until the transfer.
//
// Signals (direction seen from the unit, i.e. the slave modport):
//   flush_i  in   abort in-flight op, invalidate divide cache
//   valid_i  in   request valid
//   ready_o  out  unit can accept a request
//   op_i     in   RISC-V M funct3 (0 MUL .. 7 REMU)
//   a_i/b_i  in   rs1/rs2 operands
//   valid_o  out  result valid
//   ready_i  in   consumer takes the result
//   result_o out  result value
//   busy_o   out  iterating (MUL or DIV state)
//   state_o  out  FSM state for observation (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;
    logic [1:0]      state_o;

    modport slave (
        input  flush_i, valid_i, op_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, busy_o, state_o
    );

    modport master (
        output flush_i, valid_i, op_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o, state_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//
// Multiplies by shift-add, MUL_BITS multiplier bits per cycle; divides by
// restoring division, DIV_BITS quotient bits per cycle. Divide-by-zero, signed
// overflow and repeats of the last iterated divide (single-entry cache) finish
// without iteration.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     muldiv_unit_if slave modport (request/response handshake)
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    muldiv_unit_if.slave  bus
);
    localparam int N_M   = XLEN / MUL_BITS;
    localparam int N_D   = XLEN / DIV_BITS;
    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // MUL: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;        // multiplicand or divisor magnitude
    logic                neg_q, neg_d;        // negate product / quotient
    logic                neg_rem_q, neg_rem_d;
    logic                sgn_q, sgn_d;        // signed divide
    logic [XLEN-1:0]     a_raw_q, a_raw_d;
    logic [XLEN-1:0]     b_raw_q, b_raw_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                c_valid_q, c_valid_d;
    logic [XLEN-1:0]     c_a_q, c_a_d, c_b_q, c_b_d;
    logic                c_sgn_q, c_sgn_d;
    logic [XLEN-1:0]     c_quo_q, c_quo_d, c_rem_q, c_rem_d;

    // Request decode
    logic            a_neg, b_neg, is_div, is_rem, div_signed, b_zero, ovf, hit;
    logic [XLEN-1:0] abs_a, abs_b;

    assign a_neg      = bus.a_i[XLEN-1];
    assign b_neg      = bus.b_i[XLEN-1];
    assign abs_a      = a_neg ? -bus.a_i : bus.a_i;
    assign abs_b      = b_neg ? -bus.b_i : bus.b_i;
    assign is_div     = bus.op_i[2];
    assign is_rem     = bus.op_i[1];
    assign div_signed = ~bus.op_i[0];
    assign b_zero     = (bus.b_i == '0);
    assign ovf        = div_signed && (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b_i);
    assign hit        = c_valid_q && (c_a_q == bus.a_i) && (c_b_q == bus.b_i) && (c_sgn_q == div_signed);

    // One shift-add multiply step
    logic [MUL_BITS-1:0]      digit;
    logic [XLEN+MUL_BITS-1:0] pp, mul_sum;
    logic [2*XLEN-1:0]        mul_next, prod;
    logic [XLEN-1:0]          mul_res;

    assign digit    = acc_q[MUL_BITS-1:0];
    assign pp       = {{MUL_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, digit};
    assign mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    assign mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
    assign prod     = neg_q ? -mul_next : mul_next;
    assign mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // DIV_BITS restoring-divide steps
    logic [XLEN-1:0] rem_v, quo_v, quo_f, rem_f, div_res;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_v = acc_q[2*XLEN-1:XLEN];
        quo_v = acc_q[XLEN-1:0];
        trial = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial = {rem_v, quo_v[XLEN-1]};
            quo_v = {quo_v[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, opb_q}) begin
                trial    = trial - {1'b0, opb_q};
                quo_v[0] = 1'b1;
            end
            rem_v = trial[XLEN-1:0];
        end
    end

    assign quo_f   = neg_q ? -quo_v : quo_v;
    assign rem_f   = neg_rem_q ? -rem_v : rem_v;
    assign div_res = op_q[1] ? rem_f : quo_f;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        sgn_d     = sgn_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        result_d  = result_q;
        c_valid_d = c_valid_q;
        c_a_d     = c_a_q;
        c_b_d     = c_b_q;
        c_sgn_d   = c_sgn_q;
        c_quo_d   = c_quo_q;
        c_rem_d   = c_rem_q;

        if (bus.flush_i) begin
            state_d   = S_IDLE;
            c_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        op_d      = bus.op_i;
                        a_raw_d   = bus.a_i;
                        b_raw_d   = bus.b_i;
                        cnt_d     = '0;
                        neg_rem_d = 1'b0;
                        if (is_div) begin
                            sgn_d     = div_signed;
                            neg_d     = div_signed && (a_neg ^ b_neg);
                            neg_rem_d = div_signed && a_neg;
                            opb_d     = div_signed ? abs_b : bus.b_i;
                            acc_d     = {{XLEN{1'b0}}, (div_signed ? abs_a : bus.a_i)};
                            if (b_zero) begin
                                result_d = is_rem ? bus.a_i : '1;
                                state_d  = S_DONE;
                            end else if (ovf) begin
                                result_d = is_rem ? '0 : bus.a_i;
                                state_d  = S_DONE;
                            end else if (hit) begin
                                result_d = is_rem ? c_rem_q : c_quo_q;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_DIV;
                            end
                        end else begin
                            // MUL low half is sign-agnostic, so MUL and MULHU use raw operands
                            unique case (bus.op_i)
                                OP_MULH: begin
                                    acc_d = {{XLEN{1'b0}}, abs_a};
                                    opb_d = abs_b;
                                    neg_d = a_neg ^ b_neg;
                                end
                                OP_MULHSU: begin
                                    acc_d = {{XLEN{1'b0}}, abs_a};
                                    opb_d = bus.b_i;
                                    neg_d = a_neg;
                                end
                                default: begin
                                    acc_d = {{XLEN{1'b0}}, bus.a_i};
                                    opb_d = bus.b_i;
                                    neg_d = 1'b0;
                                end
                            endcase
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_M - 1)) begin
                        result_d = mul_res;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    acc_d = {rem_v, quo_v};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_D - 1)) begin
                        result_d  = div_res;
                        state_d   = S_DONE;
                        c_valid_d = 1'b1;
                        c_a_d     = a_raw_q;
                        c_b_d     = b_raw_q;
                        c_sgn_d   = sgn_q;
                        c_quo_d   = quo_f;
                        c_rem_d   = rem_f;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            sgn_q     <= 1'b0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            result_q  <= '0;
            c_valid_q <= 1'b0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_sgn_q   <= 1'b0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            sgn_q     <= sgn_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            result_q  <= result_d;
            c_valid_q <= c_valid_d;
            c_a_q     <= c_a_d;
            c_b_q     <= c_b_d;
            c_sgn_q   <= c_sgn_d;
            c_quo_q   <= c_quo_d;
            c_rem_q   <= c_rem_d;
        end
    end

    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.valid_o  = (state_q == S_DONE);
    assign bus.busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.result_o = result_q;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit at the default configuration and
// at XLEN=64, MUL_BITS=1, DIV_BITS=1. Latency k means the result is seen by the
// consumer on the k-th rising edge after the accepting edge.
module tb_muldiv_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) mif ();
    muldiv_unit_if #(.XLEN(64)) wif ();

    muldiv_unit #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(2)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (mif.slave)
    );

    muldiv_unit #(.XLEN(64), .MUL_BITS(1), .DIV_BITS(1)) dut_w (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (wif.slave)
    );

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec64_t;

    // Drive one request into the 32-bit unit and wait (bounded) for its result.
    // lat = -1 when no result appears within the budget.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        mif.op_i    = op;
        mif.a_i     = a;
        mif.b_i     = b;
        mif.valid_i = 1'b1;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        mif.op_i    = 3'($urandom_range(0, 7));
        mif.a_i     = $urandom;
        mif.b_i     = $urandom;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (mif.valid_o) begin
                lat = k;
                res = mif.result_o;
                break;
            end
        end
    endtask

    task automatic run_op_w(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] res, output int lat);
        @(negedge clk);
        wif.op_i    = op;
        wif.a_i     = a;
        wif.b_i     = b;
        wif.valid_i = 1'b1;
        @(posedge clk);
        #1;
        wif.valid_i = 1'b0;
        wif.a_i     = {$urandom, $urandom};
        wif.b_i     = {$urandom, $urandom};
        lat = -1;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (wif.valid_o) begin
                lat = k;
                res = wif.result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (mif.ready_o !== 1'b1 || mif.valid_o !== 1'b0 || mif.busy_o !== 1'b0 ||
            mif.result_o !== 32'h0 || mif.state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b busy=%b result=%h state=%0d, expected 1 0 0 00000000 0",
                     mif.ready_o, mif.valid_o, mif.busy_o, mif.result_o, mif.state_o);
        end
        checks++;
        if (wif.ready_o !== 1'b1 || wif.valid_o !== 1'b0 || wif.busy_o !== 1'b0 || wif.result_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_state_w: ready=%b valid=%b busy=%b result=%h, expected 1 0 0 0",
                     wif.ready_o, wif.valid_o, wif.busy_o, wif.result_o);
        end
    endtask

    task automatic test_mul();
        vec_t        v[8];
        logic [31:0] res;
        int          lat;
        v[0] = '{MUL,    32'h12345678, 32'h00000009, 32'hA3D70A38, 9};
        v[1] = '{MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 9};
        v[2] = '{MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 9};
        v[3] = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 9};
        v[4] = '{MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 9};
        v[5] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 9};
        v[6] = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 9};
        v[7] = '{MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 9};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp || lat !== v[i].lat) begin
                errors++;
                $display("FAIL mul[%0d] op=%0d a=%h b=%h: result=%h lat=%0d, expected %h lat=%0d",
                         i, v[i].op, v[i].a, v[i].b, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_div_cache();
        vec_t        v[9];
        logic [31:0] res;
        int          lat;
        v[0] = '{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 17};
        v[1] = '{REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1};
        v[2] = '{REMU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 17};
        v[3] = '{DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1};
        v[4] = '{DIV,  32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 17};
        v[5] = '{REM,  32'h00000064, 32'hFFFFFFF9, 32'h00000002, 1};
        v[6] = '{REM,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 17};
        v[7] = '{DIV,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 1};
        v[8] = '{DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 17};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp || lat !== v[i].lat) begin
                errors++;
                $display("FAIL div[%0d] op=%0d a=%h b=%h: result=%h lat=%0d, expected %h lat=%0d",
                         i, v[i].op, v[i].a, v[i].b, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_bypass();
        vec_t        v[7];
        logic [31:0] res;
        int          lat;
        v[0] = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 17};
        v[1] = '{DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1};
        v[2] = '{REMU, 32'h00001234, 32'h00000000, 32'h00001234, 1};
        v[3] = '{DIV,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
        v[4] = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        v[5] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        // bypasses above must not have displaced the unsigned entry from v[0]
        v[6] = '{REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp || lat !== v[i].lat) begin
                errors++;
                $display("FAIL bypass[%0d] op=%0d a=%h b=%h: result=%h lat=%0d, expected %h lat=%0d",
                         i, v[i].op, v[i].a, v[i].b, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        int          lat;
        @(negedge clk);
        mif.ready_i = 1'b0;
        mif.op_i    = MUL;
        mif.a_i     = 32'h12345678;
        mif.b_i     = 32'h00000009;
        mif.valid_i = 1'b1;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mif.valid_o) begin
                lat = k;
                break;
            end
        end
        held = mif.result_o;
        checks++;
        if (lat !== 9 || held !== 32'hA3D70A38) begin
            errors++;
            $display("FAIL hold_first: result=%h lat=%0d, expected a3d70a38 lat=9", held, lat);
        end
        // A request offered while DONE must be ignored
        mif.op_i    = DIVU;
        mif.a_i     = 32'h5;
        mif.b_i     = 32'h0;
        mif.valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (mif.valid_o !== 1'b1 || mif.result_o !== 32'hA3D70A38 || mif.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall[%0d]: valid=%b result=%h ready=%b, expected 1 a3d70a38 0",
                         c, mif.valid_o, mif.result_o, mif.ready_o);
            end
        end
        mif.valid_i = 1'b0;
        mif.ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (mif.ready_o !== 1'b1 || mif.valid_o !== 1'b0 || mif.result_o !== 32'hA3D70A38) begin
            errors++;
            $display("FAIL hold_release: ready=%b valid=%b result=%h, expected 1 0 a3d70a38",
                     mif.ready_o, mif.valid_o, mif.result_o);
        end
        lat = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mif.valid_o) lat++;
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL hold_ignored_req: valid_o high for %0d cycles, expected 0", lat);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          seen;
        @(negedge clk);
        mif.op_i    = DIV;
        mif.a_i     = 32'd1000;
        mif.b_i     = 32'd3;
        mif.valid_i = 1'b1;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        repeat (5) @(negedge clk);
        mif.flush_i = 1'b1;
        @(posedge clk);
        #1;
        mif.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mif.ready_o !== 1'b1 || mif.busy_o !== 1'b0 || mif.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_div: ready=%b busy=%b valid=%b, expected 1 0 0", mif.ready_o, mif.busy_o, mif.valid_o);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mif.valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: valid_o high for %0d cycles, expected 0", seen);
        end
        run_op(REM, 32'd1000, 32'd3, res, lat);
        checks++;
        if (res !== 32'd1 || lat !== 17) begin
            errors++;
            $display("FAIL flush_rem_after: result=%h lat=%0d, expected 00000001 lat=17", res, lat);
        end
        run_op(DIV, 32'd1000, 32'd3, res, lat);
        checks++;
        if (res !== 32'd333 || lat !== 1) begin
            errors++;
            $display("FAIL flush_div_hit: result=%h lat=%0d, expected 0000014d lat=1", res, lat);
        end
        // Request in the same cycle as flush is dropped; idle flush clears the cache
        @(negedge clk);
        mif.op_i    = DIVU;
        mif.a_i     = 32'h5;
        mif.b_i     = 32'h0;
        mif.valid_i = 1'b1;
        mif.flush_i = 1'b1;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        mif.flush_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mif.valid_o || !mif.ready_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_same_cycle: unit left IDLE for %0d cycles, expected 0", seen);
        end
        run_op(DIV, 32'd1000, 32'd3, res, lat);
        checks++;
        if (res !== 32'd333 || lat !== 17) begin
            errors++;
            $display("FAIL flush_idle_cache: result=%h lat=%0d, expected 0000014d lat=17", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        @(negedge clk);
        mif.op_i    = MULH;
        mif.a_i     = 32'h0000FFFF;
        mif.b_i     = 32'h00010000;
        mif.valid_i = 1'b1;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mif.busy_o !== 1'b1 || mif.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_mul_busy: busy=%b ready=%b, expected 1 0", mif.busy_o, mif.ready_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.ready_o !== 1'b1 || mif.valid_o !== 1'b0 || mif.busy_o !== 1'b0 ||
            mif.result_o !== 32'h0 || mif.state_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b busy=%b result=%h state=%0d, expected 1 0 0 00000000 0",
                     mif.ready_o, mif.valid_o, mif.busy_o, mif.result_o, mif.state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(DIV, 32'd1000, 32'd3, res, lat);
        checks++;
        if (res !== 32'd333 || lat !== 17) begin
            errors++;
            $display("FAIL reset_cache: result=%h lat=%0d, expected 0000014d lat=17", res, lat);
        end
    endtask

    task automatic test_wide();
        vec64_t      v[7];
        logic [63:0] res;
        int          lat;
        v[0] = '{MULH,  64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFF, 65};
        v[1] = '{MULHU, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h1, 65};
        v[2] = '{MUL,   64'h00000001_00000001, 64'h3, 64'h00000003_00000003, 65};
        v[3] = '{DIV,   64'hFFFFFFFF_FFFFFFF9, 64'h2, 64'hFFFFFFFF_FFFFFFFD, 65};
        v[4] = '{REM,   64'hFFFFFFFF_FFFFFFF9, 64'h2, 64'hFFFFFFFF_FFFFFFFF, 1};
        v[5] = '{DIVU,  64'h1234, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 1};
        v[6] = '{REM,   64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1};
        foreach (v[i]) begin
            run_op_w(v[i].op, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp || lat !== v[i].lat) begin
                errors++;
                $display("FAIL wide[%0d] op=%0d a=%h b=%h: result=%h lat=%0d, expected %h lat=%0d",
                         i, v[i].op, v[i].a, v[i].b, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    initial begin
        mif.flush_i = 1'b0;
        mif.valid_i = 1'b0;
        mif.op_i    = '0;
        mif.a_i     = '0;
        mif.b_i     = '0;
        mif.ready_i = 1'b1;
        wif.flush_i = 1'b0;
        wif.valid_i = 1'b0;
        wif.op_i    = '0;
        wif.a_i     = '0;
        wif.b_i     = '0;
        wif.ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_mul();
        test_div_cache();
        test_bypass();
        test_hold();
        test_flush();
        test_async_reset();
        test_wide();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative RISC-V M-extension unit replacing the fixed-width multiply/divide datapath in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes in a configurable number of bits per cycle. It resolves divide-by-zero and signed overflow in a single cycle, and reuses a cached quotient/remainder pair when a DIV/REM with identical operands follows. The ALU forwards M-ops to this block and stalls the pipeline while `ready_o` or `valid_o` is withheld.

## Interface
- `XLEN`, default 32: operand and result width; must be a multiple of both step parameters.
- `MUL_BITS`, default 4: multiplier bits retired per cycle; legal values 1, 2, 4.
- `DIV_BITS`, default 2: quotient bits retired per cycle; legal values 1, 2.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset; one clock; asynchronous, active-low.
- `flush_i`, in, 1: abort the in-flight operation and invalidate the cache.
- `valid_i`, in, 1: request valid.
- `ready_o`, out, 1: unit can accept a request.
- `op_i`, in, 3: RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a_i`, in, XLEN: rs1 operand.
- `b_i`, in, XLEN: rs2 operand.
- `valid_o`, out, 1: result valid.
- `ready_i`, in, 1: consumer takes the result.
- `result_o`, out, XLEN: result value.
- `busy_o`, out, 1: high in MUL or DIV state.

## Operation
- States: IDLE, MUL, DIV, DONE. `ready_o` = (state==IDLE).
- Accept = `valid_i && ready_o`. On accept, the unit latches op, operand sign flags, and absolute values.
  - MULHU and unsigned divides take raw operands.
  - MULHSU takes abs(a) and raw b.
- MUL state: shift-add over a 2·XLEN accumulator, `MUL_BITS` multiplier bits per cycle, N_M = XLEN/MUL_BITS cycles.
- DIV state: restoring divide, `DIV_BITS` quotient bits per cycle, N_D = XLEN/DIV_BITS cycles.
- Final result is formed on transition to DONE:
  - Product is negated when the sign flag is set. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Unsigned ops apply no fixup.
- Bypass paths: go IDLE→DONE directly, with no iteration.
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = 1<<(XLEN-1), b = all-ones): DIV gives a; REM gives 0.
  - Cache hit, defined below.
- Cache holds {a, b, signedness, quotient, remainder, valid}.
  - Written when a DIV-state operation completes.
  - A DIV/DIVU/REM/REMU whose a, b and signedness (DIV/REM signed, DIVU/REMU unsigned) match a valid entry is a hit and returns the stored value.
  - Invalidated by `flush_i` and by reset.
  - Bypass results (b==0, overflow) are not cached.
- DONE: `valid_o`=1 and `result_o` held stable until `ready_i`. On `valid_o && ready_i` the state goes to IDLE.
- `flush_i` has priority over every other event in every state:
  - Next state is IDLE and `valid_o` drops the next cycle.
  - A request accepted in the same cycle as `flush_i` is discarded.
  - Cache valid is cleared.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `busy_o`=0, `result_o`=0, cache valid 0.
- Reset asserted mid-operation returns to IDLE immediately, asynchronously.
- Accept at edge t. `valid_o` rises at:
  - MUL ops: t+1+N_M (t+9 at defaults).
  - Iterated div ops: t+1+N_D (t+17 at defaults).
  - Bypass or cache hit: t+1.
- No back-to-back overlap. The next accept occurs at earliest in the cycle after the result handshake, because `ready_o` is low in DONE.
- `result_o` is registered and changes only on entry to DONE. It retains its last value in IDLE.
- Inputs are sampled only on accept; later changes to `a_i`/`b_i`/`op_i` have no effect.

## Test plan
- MULH, a=0xFFFFFFFF (−1), b=0x00000002 → result 0xFFFFFFFF. Also MULHU with the same operands → 0x00000001. Both with `valid_o` at t+9.
- DIV, a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD at t+17. Then REM with the same operands → 0xFFFFFFFF at t+1 (cache hit). Then REMU with the same operands → iterated result 0x00000001 at t+17 (signedness mismatch).
- DIVU, a=0x1234, b=0 → 0xFFFFFFFF at t+1. REM, a=0x80000000, b=0xFFFFFFFF → 0x00000000 at t+1. DIV with the same operands → 0x80000000.
- Hold `ready_i`=0 for 5 cycles after DONE → `valid_o` and `result_o` stable, `ready_o` low, `valid_i` ignored. Release → IDLE next cycle.
- `flush_i` at cycle 5 of a DIV → `valid_o` never asserts, `ready_o`=1 next cycle. A following REM with the same operands takes the full N_D latency (cache invalidated).
- Assert `rst_ni` low asynchronously mid-MUL → all outputs at reset values before the next edge. Repeat the directed checks with XLEN=64, MUL_BITS=1, DIV_BITS=1 → latencies t+65.
